// File: rtl/patch_sweep_pkg.sv
// Shared state encoding, patch input bit positions and sweep-range helper for the patch sweep checker.
package patch_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int IDX_G1  = 0;
    localparam int IDX_G5  = 1;
    localparam int IDX_N29 = 2;

    function automatic int last_vec(input int num_in);
        return (1 << num_in) - 1;
    endfunction

endpackage

// File: rtl/patch_sweep_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
// Latency: count updates on the edge after inc/clr.
// Backpressure: none; increments at all-ones are dropped.
module patch_sweep_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] MAX = '1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != MAX)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/patch_sweep_checker.sv
// Exhaustive sweep of the ECO patch inputs, comparing patch vs golden output per vector.
// Latency: SETTLE_CYC+1 cycles per vector; PATCH_SWEEP_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
// Backpressure: none; start is only accepted in IDLE or DONE and ignored while busy.
module patch_sweep_checker #(
    parameter int NUM_IN     = 3,
    parameter int SETTLE_CYC = 1,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [NUM_IN-1:0] vec_out,
    input  logic              patch_out,
    input  logic              golden_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  mismatch_cnt,
    output logic [NUM_IN-1:0] first_fail_vec,
    output logic              first_fail_valid
);

    import patch_sweep_pkg::*;

    localparam int                SW         = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [NUM_IN-1:0] LAST       = NUM_IN'(last_vec(NUM_IN));
    localparam logic [SW-1:0]     SETTLE_END = SW'(SETTLE_CYC - 1);

    generate
        if (SETTLE_CYC < 1) begin : g_bad_settle
            $error("patch_sweep_checker: SETTLE_CYC must be >= 1");
        end
    endgenerate

    state_t        state;
    logic [SW-1:0] settle_cnt;
    logic          accept;
    logic          mis;
    logic          stop;

    assign accept = start && ((state == IDLE) || (state == DONE));
    assign mis    = (state == COMPARE) && (patch_out ^ golden_out);

`ifdef PATCH_SWEEP_STOP_ON_FAIL_EN
    assign stop = mis;
`else
    assign stop = 1'b0;
`endif

    patch_sweep_sat_cnt #(.W(CNT_W)) u_mis_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .inc   (mis),
        .cnt   (mismatch_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            vec_out          <= '0;
            settle_cnt       <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else if (accept) begin
            state            <= SETTLE;
            vec_out          <= '0;
            settle_cnt       <= '0;
            busy             <= 1'b1;
            done             <= 1'b0;
            pass             <= 1'b0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            case (state)
                SETTLE: begin
                    if (settle_cnt == SETTLE_END) begin
                        state <= COMPARE;
                    end else begin
                        settle_cnt <= settle_cnt + SW'(1);
                    end
                end
                COMPARE: begin
                    settle_cnt <= '0;
                    if (mis && !first_fail_valid) begin
                        first_fail_vec   <= vec_out;
                        first_fail_valid <= 1'b1;
                    end
                    // Counter output still lags this edge, so fold in the current sample.
                    if ((vec_out == LAST) || stop) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (mismatch_cnt == '0) && !mis;
                    end else begin
                        vec_out <= vec_out + NUM_IN'(1);
                        state   <= SETTLE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_patch_sweep_checker.sv
// Directed bench for patch_sweep_checker: scoreboarded sweeps on a default and a CNT_W=2/SETTLE_CYC=3 instance.
`timescale 1ns/1ps
module tb_patch_sweep_checker;

    import patch_sweep_pkg::*;

`ifdef PATCH_SWEEP_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    typedef struct {
        int cycles;
        int cnt;
        int ffv;
        int ffvalid;
        int pass;
        int vec_last;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start0 = 1'b0, start1 = 1'b0;
    logic [7:0] pat0 = 8'h00, pat1 = 8'h00;

    logic [2:0] vec0, vec1, ffv0, ffv1;
    logic       po0, go0, po1, go1;
    logic       busy0, done0, pass0, ffvld0;
    logic       busy1, done1, pass1, ffvld1;
    logic [7:0] cnt0;
    logic [1:0] cnt1;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    function automatic logic patch_fn(input logic [2:0] v);
        return (v[IDX_G1] & v[IDX_G5]) | v[IDX_N29];
    endfunction

    // Golden output differs from the patch exactly on vectors flagged in the pattern.
    assign po0 = patch_fn(vec0);
    assign go0 = po0 ^ pat0[vec0];
    assign po1 = patch_fn(vec1);
    assign go1 = po1 ^ pat1[vec1];

    patch_sweep_checker u_dut0 (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start0),
        .vec_out          (vec0),
        .patch_out        (po0),
        .golden_out       (go0),
        .busy             (busy0),
        .done             (done0),
        .pass             (pass0),
        .mismatch_cnt     (cnt0),
        .first_fail_vec   (ffv0),
        .first_fail_valid (ffvld0)
    );

    patch_sweep_checker #(.NUM_IN(3), .SETTLE_CYC(3), .CNT_W(2)) u_dut1 (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start1),
        .vec_out          (vec1),
        .patch_out        (po1),
        .golden_out       (go1),
        .busy             (busy1),
        .done             (done1),
        .pass             (pass1),
        .mismatch_cnt     (cnt1),
        .first_fail_vec   (ffv1),
        .first_fail_valid (ffvld1)
    );

    function automatic exp_t model(input logic [7:0] pat, input int cnt_max, input int settle);
        exp_t e;
        e.cycles   = 0;
        e.cnt      = 0;
        e.ffv      = 0;
        e.ffvalid  = 0;
        e.vec_last = 0;
        for (int v = 0; v < 8; v++) begin
            e.cycles  += settle + 1;
            e.vec_last = v;
            if (pat[v]) begin
                if (e.cnt < cnt_max) e.cnt++;
                if (e.ffvalid == 0) begin
                    e.ffv     = v;
                    e.ffvalid = 1;
                end
                if (STOP) break;
            end
        end
        e.pass = (e.cnt == 0) ? 1 : 0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_sweep(input int inst, input logic [7:0] pat, input bit repulse);
        exp_t e;
        int   n;
        bit   got;
        if (inst == 0) begin
            pat0 = pat;
            sb.push_back(model(pat, 255, 1));
            start0 = 1'b1;
        end else begin
            pat1 = pat;
            sb.push_back(model(pat, 3, 3));
            start1 = 1'b1;
        end
        tick();
        start0 = 1'b0;
        start1 = 1'b0;
        chk("start_busy",    (inst == 0) ? busy0  : busy1,            1);
        chk("start_done",    (inst == 0) ? done0  : done1,            0);
        chk("start_cnt",     (inst == 0) ? cnt0   : {6'd0, cnt1},     0);
        chk("start_ffvalid", (inst == 0) ? ffvld0 : ffvld1,           0);
        chk("start_vec",     (inst == 0) ? vec0   : vec1,             0);
        n   = 0;
        got = 1'b0;
        while (!got && n < 400) begin
            if (repulse && (n == 3 || n == 9) && busy0) start0 = 1'b1;
            tick();
            start0 = 1'b0;
            n++;
            got = (inst == 0) ? done0 : done1;
        end
        e = sb.pop_front();
        chk("done_seen",   got, 1);
        chk("done_cycles", n, e.cycles);
        chk("end_busy",    (inst == 0) ? busy0  : busy1,        0);
        chk("end_pass",    (inst == 0) ? pass0  : pass1,        e.pass);
        chk("end_cnt",     (inst == 0) ? cnt0   : {6'd0, cnt1}, e.cnt);
        chk("end_ffvalid", (inst == 0) ? ffvld0 : ffvld1,       e.ffvalid);
        chk("end_ffv",     (inst == 0) ? ffv0   : ffv1,         e.ffv);
        chk("end_vec",     (inst == 0) ? vec0   : vec1,         e.vec_last);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_vec",     vec0,   0);
        chk("rst_busy",    busy0,  0);
        chk("rst_done",    done0,  0);
        chk("rst_pass",    pass0,  0);
        chk("rst_cnt",     cnt0,   0);
        chk("rst_ffv",     ffv0,   0);
        chk("rst_ffvalid", ffvld0, 0);
        chk("rst_done1",   done1,  0);
        rst_n = 1'b1;
        tick();

        // Clean sweep, single mismatch, then ignored re-pulses with two mismatches.
        run_sweep(0, 8'h00, 1'b0);
        run_sweep(0, 8'h20, 1'b0);
        run_sweep(0, 8'h44, 1'b1);
        // Restart from DONE after a failing sweep must clear the previous result.
        run_sweep(0, 8'h00, 1'b0);

        // Reset in the middle of a failing sweep.
        pat0   = 8'hFF;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (7) tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vec",     vec0,   0);
        chk("mid_rst_busy",    busy0,  0);
        chk("mid_rst_done",    done0,  0);
        chk("mid_rst_pass",    pass0,  0);
        chk("mid_rst_cnt",     cnt0,   0);
        chk("mid_rst_ffv",     ffv0,   0);
        chk("mid_rst_ffvalid", ffvld0, 0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (40) tick();
        chk("post_rst_done", done0, 0);
        chk("post_rst_busy", busy0, 0);
        chk("post_rst_cnt",  cnt0,  0);

        // Narrow counter saturation and longer settle on the second instance.
        run_sweep(1, 8'hFF, 1'b0);
        run_sweep(1, 8'h04, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
